// File: rtl/halflife_sequencer.sv
// Half-life decay sequencer: loads a quantity, halves it once per programmed
// period until it reaches zero, and emits load/up strobes for the external counter.
module halflife_sequencer #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         pause,
    input  logic [P-1:0] period,
    input  logic [W-1:0] init_q,
    output logic [W-1:0] q,
    output logic [N-1:0] halvings,
    output logic         busy,
    output logic         done,
    output logic         tick,
    output logic         ctr_load,
    output logic         ctr_up
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state_reg, state_next;
    logic [W-1:0] q_reg, q_next;
    logic [N-1:0] halvings_reg, halvings_next;
    logic [P-1:0] presc_reg, presc_next;
    logic [P-1:0] per_reg, per_next;

    logic         idle_or_done;
    logic         start_ok;
    logic         tick_fire;
    logic [W-1:0] q_half;
    logic [N-1:0] halvings_inc;

    assign idle_or_done = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign q_half       = q_reg >> 1;
    assign halvings_inc = (&halvings_reg) ? halvings_reg : halvings_reg + N'(1);

    // Strobes are gated by reset and abort so nothing fires on a cycle that is being discarded.
    assign start_ok  = rst && !abort && start && (period != '0) && idle_or_done;
    assign tick_fire = rst && !abort && (state_reg == ST_RUN) && !pause && (presc_reg == '0);

    always_comb begin
        state_next    = state_reg;
        q_next        = q_reg;
        halvings_next = halvings_reg;
        presc_next    = presc_reg;
        per_next      = per_reg;
        if (abort) begin
            state_next    = ST_IDLE;
            q_next        = '0;
            halvings_next = '0;
            presc_next    = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start && (period != '0)) begin
                        halvings_next = '0;
                        if (init_q == '0) begin
                            state_next = ST_DONE;
                            q_next     = '0;
                        end else begin
                            state_next = ST_RUN;
                            q_next     = init_q;
                            per_next   = period;
                            presc_next = period - P'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (!pause) begin
                        if (presc_reg != '0) begin
                            presc_next = presc_reg - P'(1);
                        end else begin
                            q_next        = q_half;
                            halvings_next = halvings_inc;
                            presc_next    = per_reg - P'(1);
                            if (q_half == '0) begin
                                state_next = ST_DONE;
                            end
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            q_reg        <= '0;
            halvings_reg <= '0;
            presc_reg    <= '0;
            per_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            q_reg        <= q_next;
            halvings_reg <= halvings_next;
            presc_reg    <= presc_next;
            per_reg      <= per_next;
        end
    end

    assign q        = q_reg;
    assign halvings = halvings_reg;
    assign busy     = (state_reg == ST_RUN);
    assign done     = (state_reg == ST_DONE);
    assign tick     = tick_fire;
    assign ctr_up   = tick_fire;
    assign ctr_load = start_ok;

endmodule

// File: tb/tb_halflife_sequencer.sv
// Directed bench for halflife_sequencer: default instance for decay/pause/abort
// scenarios, a narrow-counter wide-quantity instance for halvings saturation.
module tb_halflife_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, pause;
    logic [7:0]  period, init_q, q;
    logic [3:0]  halvings;
    logic        busy, done, tick, ctr_load, ctr_up;

    logic        start2, abort2, pause2;
    logic [7:0]  period2;
    logic [15:0] init_q2, q2;
    logic [2:0]  halvings2;
    logic        busy2, done2, tick2, ctr_load2, ctr_up2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    halflife_sequencer #(.N(4), .W(8), .P(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .period(period), .init_q(init_q), .q(q), .halvings(halvings),
        .busy(busy), .done(done), .tick(tick), .ctr_load(ctr_load), .ctr_up(ctr_up)
    );

    halflife_sequencer #(.N(3), .W(16), .P(8)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .pause(pause2),
        .period(period2), .init_q(init_q2), .q(q2), .halvings(halvings2),
        .busy(busy2), .done(done2), .tick(tick2), .ctr_load(ctr_load2), .ctr_up(ctr_up2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench 2 time units after the rising edge, ready to drive inputs.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starts a run on the default instance and walks it cycle by cycle until done.
    // tmask bit c set means a tick is expected in cycle c after the accepting edge.
    task automatic run_seq(input string name, input int iq, input int per,
                           input int plo, input int phi,
                           input logic [63:0] tmask, input int done_c);
        logic [7:0] eq;
        logic [3:0] eh;
        int         ups;
        init_q = 8'(iq);
        period = 8'(per);
        start  = 1'b1;
        #1;
        check({name, ":ctr_load"}, 32'(ctr_load), 32'd1);
        step();
        start = 1'b0;
        eq    = 8'(iq);
        eh    = 4'd0;
        ups   = 0;
        for (int c = 1; c <= done_c; c++) begin
            pause = (c >= plo) && (c <= phi);
            #1;
            check({name, ":tick"},    32'(tick),     32'(tmask[c]));
            check({name, ":ctr_up"},  32'(ctr_up),   32'(tmask[c]));
            check({name, ":ctr_load"},32'(ctr_load), 32'd0);
            check({name, ":busy"},    32'(busy),     32'(c < done_c));
            check({name, ":done"},    32'(done),     32'(c == done_c));
            check({name, ":q"},       32'(q),        32'(eq));
            check({name, ":halv"},    32'(halvings), 32'(eh));
            if (ctr_up) ups++;
            if (tmask[c]) begin
                eq = eq >> 1;
                if (eh != 4'hF) eh = eh + 4'd1;
            end
            step();
        end
        pause = 1'b0;
        check({name, ":up_count"}, 32'(ups), 32'($countones(tmask)));
        $display("txn %s init_q=%0d period=%0d cycles=%0d", name, iq, per, done_c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b1; abort = 1'b0; pause = 1'b0;
        period = 8'd3; init_q = 8'd5;
        start2 = 1'b0; abort2 = 1'b0; pause2 = 1'b0; period2 = 8'd0; init_q2 = 16'd0;

        // Reset held for two edges with start asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            check("rst:q",        32'(q),        32'd0);
            check("rst:halv",     32'(halvings), 32'd0);
            check("rst:busy",     32'(busy),     32'd0);
            check("rst:done",     32'(done),     32'd0);
            check("rst:tick",     32'(tick),     32'd0);
            check("rst:ctr_load", 32'(ctr_load), 32'd0);
            check("rst:ctr_up",   32'(ctr_up),   32'd0);
            check("rst:q2",       32'(q2),       32'd0);
        end
        start = 1'b0;
        rst   = 1'b1;
        step();
        #1;
        check("idle:busy", 32'(busy), 32'd0);
        check("idle:done", 32'(done), 32'd0);
        $display("txn reset");
        #1;

        // Ticks at cycles 3,6,...,24; done at 25.
        run_seq("basic", 200, 3, 0, 0, 64'h0000_0000_0124_9248, 25);
        // Restart from DONE; pause cycles 2-4 push ticks to 5,7,9; done at 10.
        run_seq("pause", 4, 2, 2, 4, 64'h0000_0000_0000_02A0, 10);
        #1;
        check("restart:done_hold", 32'(done), 32'd1);
        check("restart:q_hold",    32'(q),    32'd0);
        #1;

        // Abort from DONE returns to IDLE.
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        check("abort_done:done", 32'(done), 32'd0);
        check("abort_done:busy", 32'(busy), 32'd0);
        #1;

        // period==0 start is ignored.
        period = 8'd0; init_q = 8'd9; start = 1'b1;
        #1;
        check("per0:ctr_load", 32'(ctr_load), 32'd0);
        step();
        start = 1'b0;
        #1;
        check("per0:busy", 32'(busy), 32'd0);
        check("per0:done", 32'(done), 32'd0);
        $display("txn period_zero");
        #1;

        // init_q==0 goes straight to DONE.
        period = 8'd5; init_q = 8'd0; start = 1'b1;
        #1;
        check("q0:ctr_load", 32'(ctr_load), 32'd1);
        step();
        start = 1'b0;
        #1;
        check("q0:done", 32'(done), 32'd1);
        check("q0:busy", 32'(busy), 32'd0);
        check("q0:q",    32'(q),    32'd0);
        $display("txn init_zero");
        #1;

        // Abort in a would-be tick cycle: tick at 2 happens, abort at cycle 4.
        period = 8'd2; init_q = 8'd8; start = 1'b1;
        step();
        start = 1'b0;
        step();
        #1;
        check("abrt:tick2", 32'(tick), 32'd1);
        #1;
        step();
        step();
        abort = 1'b1;
        #1;
        check("abrt:q_before",    32'(q),        32'd4);
        check("abrt:halv_before", 32'(halvings), 32'd1);
        check("abrt:tick",        32'(tick),     32'd0);
        check("abrt:ctr_up",      32'(ctr_up),   32'd0);
        step();
        abort = 1'b0;
        #1;
        check("abrt:busy", 32'(busy),     32'd0);
        check("abrt:done", 32'(done),     32'd0);
        check("abrt:q",    32'(q),        32'd0);
        check("abrt:halv", 32'(halvings), 32'd0);
        $display("txn abort_tick");
        #1;

        // start and abort together stay IDLE.
        period = 8'd2; init_q = 8'd8; start = 1'b1; abort = 1'b1;
        #1;
        check("sa:ctr_load", 32'(ctr_load), 32'd0);
        step();
        start = 1'b0; abort = 1'b0;
        #1;
        check("sa:busy", 32'(busy), 32'd0);
        $display("txn start_abort");
        #1;

        // start while RUN is ignored; tick schedule unaffected.
        period = 8'd4; init_q = 8'd8; start = 1'b1;
        step();
        init_q = 8'd100; period = 8'd1;
        #1;
        check("srun:ctr_load", 32'(ctr_load), 32'd0);
        check("srun:tick1",    32'(tick),     32'd0);
        #1;
        step();
        start = 1'b0;
        #1;
        check("srun:busy", 32'(busy), 32'd1);
        check("srun:q",    32'(q),    32'd8);
        #1;
        step();
        step();
        #1;
        check("srun:tick4", 32'(tick), 32'd1);
        #1;
        step();
        #1;
        check("srun:q_after", 32'(q), 32'd4);
        #1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        $display("txn start_in_run");

        // Saturation instance: period 1, 16 ticks, halvings stops at 7.
        init_q2 = 16'hFFFF; period2 = 8'd1; start2 = 1'b1;
        #1;
        check("sat:ctr_load", 32'(ctr_load2), 32'd1);
        step();
        start2 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            #1;
            check("sat:tick", 32'(tick2),     32'(c <= 16));
            check("sat:busy", 32'(busy2),     32'(c <= 16));
            check("sat:done", 32'(done2),     32'(c == 17));
            check("sat:q",    32'(q2),        32'hFFFF >> (c - 1));
            check("sat:halv", 32'(halvings2), (c - 1 > 7) ? 32'd7 : 32'(c - 1));
            step();
        end
        $display("txn saturation");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
